cook_timer_ctrl: RTL and testbench
==================================

# cook_timer_ctrl

Countdown sequencer for the microwave cooking cycle. Consumes the single-cycle `tick` pulses from the clock prescaler, accumulates them into seconds, and counts a user-loaded MM:SS time down to zero. Drives the magnetron and lamp enables and runs a timed end-of-cycle beep. It is the only block that clears the prescaler, so every cook cycle starts on a full second.

## Interface
Parameters:
- `TICKS_PER_SEC`, 100: `tick` pulses per second (1..255).
- `BEEP_SECS`, 3: beep duration in seconds (1..15).

Ports:
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `tick` in 1: prescaler pulse, one `clk` wide.
- `load` in 1: latch `min_in`/`sec_in`; honoured in IDLE only.
- `min_in` in 7: minutes, binary; values >99 are clamped to 99.
- `sec_in` in 6: seconds, binary; values >59 are clamped to 59.
- `start` in 1: start or resume (level; acted on when sampled).
- `pause` in 1: pause request.
- `cancel` in 1: abort and clear the time.
- `door_open` in 1: door switch, already synchronised.
- `mins` out 7: remaining minutes.
- `secs` out 6: remaining seconds.
- `magnetron` out 1: heating enable.
- `lamp` out 1: cavity lamp.
- `beep` out 1: buzzer enable.
- `presc_clr` out 1: one-cycle synchronous clear to the prescaler.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, RUN, PAUSED, DONE.
- Per-cycle command priority: `reset` > `cancel` > `door_open` > `pause` > `start` > `load`.
- `cancel` (any state): go to IDLE, clear `mins`/`secs` to 0, clear the sub-second counter, clear the beep counter.
- IDLE:
  - `load`: latch the clamped inputs.
  - `start` with door closed and time ≠ 00:00: go to RUN, pulse `presc_clr`, clear the sub-second counter.
  - `start` with time 00:00 or door open: ignored.
- RUN:
  - Each `tick` increments the sub-second counter (width clog2(`TICKS_PER_SEC`)).
  - On the tick that would reach `TICKS_PER_SEC`: counter goes to 0 and MM:SS decrements by one second.
  - Decrement with `secs`=0 borrows: `secs`→59, `mins`→`mins`−1.
  - Decrement from 00:01: result is 00:00 and the state goes to DONE in the same cycle.
  - `door_open` or `pause`: go to PAUSED. The sub-second counter is held, and a `tick` in that cycle is not counted.
- PAUSED:
  - Time and sub-second counter are frozen.
  - `start` with door closed: go to RUN. No `presc_clr`; the partial second is preserved.
  - `load` is ignored.
- DONE:
  - `beep`=1.
  - Counts `BEEP_SECS`×`TICKS_PER_SEC` ticks, then goes to IDLE.
  - `start`, `load`, `pause` and `door_open` are ignored; `cancel` goes to IDLE at once.

Output rules:
- `magnetron` = (state==RUN).
- `lamp` = (state==RUN) | `door_open`.
- `beep` = (state==DONE).
- `busy` = (state≠IDLE).

## Timing
- All outputs are registered. Reset value is 0 for every output, every counter and the time; the state resets to IDLE.
- Command latency: the command is sampled at edge N, and the state and outputs change after edge N.
- `presc_clr`:
  - High exactly one cycle, the cycle after the IDLE→RUN edge.
  - The first counted `tick` is the first one sampled after that pulse.
  - A `tick` coincident with the start edge is not counted.
- Simultaneous events:
  - `tick` completing a second together with `pause`: pause wins, no decrement.
  - `tick` completing 00:01→00:00 together with `cancel`: cancel wins, IDLE with 00:00, no beep.
- `reset` mid-RUN: after the next edge `magnetron`=0 and the time is 00:00.
- Throughput: at most one second is decremented per cycle. `TICKS_PER_SEC`=1 is legal and decrements on every `tick`.

## Structure
- Package `cook_timer_pkg`:
  - state enum (IDLE, RUN, PAUSED, DONE),
  - `MAX_MIN`=99, `MAX_SEC`=59,
  - clamp function for `min_in`/`sec_in`.
- Sub-module `mmss_down_counter`:
  - ports: load, dec, clear, min_in, sec_in;
  - outputs: mins, secs, zero_next (time is 00:01);
  - implements the borrow logic.
- Top level: FSM, sub-second counter, beep counter, output registers.

## Test plan
All scenarios use `TICKS_PER_SEC`=4 and `BEEP_SECS`=2.
1. Load 01:02, start, supply 12 ticks:
   - `presc_clr` pulses once;
   - time steps 01:01, 01:00, 00:59;
   - `magnetron`=1 throughout.
2. Load 00:02, start, supply 8 ticks:
   - DONE on the 8th tick, `magnetron` falls the same cycle;
   - `beep`=1 for exactly 8 further ticks, then IDLE with `busy`=0.
3. In RUN at 00:05 after 2 ticks of the current second, assert `door_open`:
   - PAUSED, `lamp`=1, time frozen over 10 ticks.
   - Close the door, `start`: 2 more ticks reach 00:04, and no `presc_clr`.
4. Load `min_in`=120, `sec_in`=63 → 99:59. Load 00:00 then `start` → remains IDLE.
5. `tick` completing 00:01 coincident with `cancel` → IDLE, 00:00, `beep` never asserted.
6. Assert `reset` for one cycle mid-RUN at 03:30 → all outputs 0, IDLE, time 00:00.

Source files
------------

// File: rtl/cook_timer_pkg.sv
// Shared state encoding, time limits and input clamping for the cook timer.
package cook_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [6:0] MAX_MIN = 7'd99;
    localparam logic [5:0] MAX_SEC = 6'd59;

    function automatic logic [6:0] clamp_min(input logic [6:0] v);
        return (v > MAX_MIN) ? MAX_MIN : v;
    endfunction

    function automatic logic [5:0] clamp_sec(input logic [5:0] v);
        return (v > MAX_SEC) ? MAX_SEC : v;
    endfunction

endpackage

// File: rtl/mmss_down_counter.sv
// MM:SS register pair with clamped load and one-second decrement including the
// seconds-to-minutes borrow.
module mmss_down_counter
    import cook_timer_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_load,
    input  logic       i_dec,
    input  logic       i_clear,
    input  logic [6:0] i_min_in,
    input  logic [5:0] i_sec_in,
    output logic [6:0] o_mins,
    output logic [5:0] o_secs,
    output logic       o_zero_next
);

    logic [6:0] r_mins;
    logic [5:0] r_secs;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_mins <= '0;
            r_secs <= '0;
        end else if (i_load) begin
            r_mins <= clamp_min(i_min_in);
            r_secs <= clamp_sec(i_sec_in);
        end else if (i_dec) begin
            if (r_secs != 6'd0) begin
                r_secs <= r_secs - 6'd1;
            end else if (r_mins != 7'd0) begin
                r_secs <= MAX_SEC;
                r_mins <= r_mins - 7'd1;
            end
        end
    end

    assign o_mins      = r_mins;
    assign o_secs      = r_secs;
    assign o_zero_next = (r_mins == 7'd0) && (r_secs == 6'd1);

endmodule

// File: rtl/cook_timer_ctrl.sv
// Microwave cook-cycle sequencer: tick accumulation, MM:SS countdown, heater/lamp
// enables and the timed end-of-cycle beep.
//   state   | meaning
//   IDLE    | time loadable, waiting for start
//   RUN     | magnetron on, counting ticks into seconds
//   PAUSED  | door open or paused, time and partial second frozen
//   DONE    | beeping for BEEP_SECS seconds, then back to IDLE
module cook_timer_ctrl
    import cook_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int BEEP_SECS     = 3
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick,
    input  logic       i_load,
    input  logic [6:0] i_min_in,
    input  logic [5:0] i_sec_in,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_cancel,
    input  logic       i_door_open,
    output logic [6:0] o_mins,
    output logic [5:0] o_secs,
    output logic       o_magnetron,
    output logic       o_lamp,
    output logic       o_beep,
    output logic       o_presc_clr,
    output logic       o_busy
);

    localparam int BEEP_TOTAL = BEEP_SECS * TICKS_PER_SEC;
    localparam int SUB_W      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int BEEP_W     = (BEEP_TOTAL > 1) ? $clog2(BEEP_TOTAL) : 1;
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(TICKS_PER_SEC - 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_TOTAL - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SUB_W-1:0]    r_sub;
    logic [SUB_W-1:0]    w_sub_nxt;
    logic [BEEP_W-1:0]   r_beep_cnt;
    logic [BEEP_W-1:0]   w_beep_nxt;
    logic                r_magnetron;
    logic                r_lamp;
    logic                r_beep;
    logic                r_presc_clr;
    logic                r_busy;
    logic                w_load;
    logic                w_dec;
    logic                w_clear;
    logic                w_zero_next;
    logic                w_time_zero;
    logic [6:0]          w_mins;
    logic [5:0]          w_secs;

    mmss_down_counter u_mmss (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (w_load),
        .i_dec       (w_dec),
        .i_clear     (w_clear),
        .i_min_in    (i_min_in),
        .i_sec_in    (i_sec_in),
        .o_mins      (w_mins),
        .o_secs      (w_secs),
        .o_zero_next (w_zero_next)
    );

    assign w_time_zero = (w_mins == 7'd0) && (w_secs == 6'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_sub_nxt   = r_sub;
        w_beep_nxt  = r_beep_cnt;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_clear     = 1'b0;
        if (i_cancel) begin
            w_state_nxt = ST_IDLE;
            w_sub_nxt   = '0;
            w_beep_nxt  = '0;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!i_door_open && !i_pause) begin
                        if (i_start) begin
                            if (!w_time_zero) begin
                                w_state_nxt = ST_RUN;
                                w_sub_nxt   = '0;
                            end
                        end else if (i_load) begin
                            w_load = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // The prescaler is being cleared this cycle, so its tick is stale.
                    if (i_door_open || i_pause) begin
                        w_state_nxt = ST_PAUSED;
                    end else if (i_tick && !r_presc_clr) begin
                        if (r_sub == SUB_LAST) begin
                            w_sub_nxt = '0;
                            w_dec     = 1'b1;
                            if (w_zero_next) begin
                                w_state_nxt = ST_DONE;
                                w_beep_nxt  = '0;
                            end
                        end else begin
                            w_sub_nxt = r_sub + SUB_W'(1);
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!i_door_open && !i_pause && i_start) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (i_tick) begin
                        if (r_beep_cnt == BEEP_LAST) begin
                            w_state_nxt = ST_IDLE;
                            w_beep_nxt  = '0;
                        end else begin
                            w_beep_nxt = r_beep_cnt + BEEP_W'(1);
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_sub       <= '0;
            r_beep_cnt  <= '0;
            r_magnetron <= 1'b0;
            r_lamp      <= 1'b0;
            r_beep      <= 1'b0;
            r_presc_clr <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sub       <= w_sub_nxt;
            r_beep_cnt  <= w_beep_nxt;
            r_magnetron <= (w_state_nxt == ST_RUN);
            r_lamp      <= (w_state_nxt == ST_RUN) || i_door_open;
            r_beep      <= (w_state_nxt == ST_DONE);
            r_presc_clr <= (r_state == ST_IDLE) && (w_state_nxt == ST_RUN);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign o_mins      = w_mins;
    assign o_secs      = w_secs;
    assign o_magnetron = r_magnetron;
    assign o_lamp      = r_lamp;
    assign o_beep      = r_beep;
    assign o_presc_clr = r_presc_clr;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Scoreboard bench for cook_timer_ctrl: directed cook scenarios followed by random
// command traffic, checked against a remaining-seconds reference model.
module tb_cook_timer_ctrl;

    localparam int TPS   = 4;
    localparam int BSECS = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic reset = 1'b0, tick = 1'b0, load = 1'b0, start = 1'b0;
    logic pause = 1'b0, cancel = 1'b0, door_open = 1'b0;
    logic [6:0] min_in = '0;
    logic [5:0] sec_in = '0;
    logic [6:0] mins;
    logic [5:0] secs;
    logic magnetron, lamp, beep, presc_clr, busy;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q[$];
    logic [17:0] mon_exp, mon_got;

    int m_mode = M_IDLE;
    int m_remain = 0;
    int m_frac = 0;
    int m_beep = 0;
    bit m_clr = 1'b0;

    cook_timer_ctrl #(.TICKS_PER_SEC(TPS), .BEEP_SECS(BSECS)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_tick      (tick),
        .i_load      (load),
        .i_min_in    (min_in),
        .i_sec_in    (sec_in),
        .i_start     (start),
        .i_pause     (pause),
        .i_cancel    (cancel),
        .i_door_open (door_open),
        .o_mins      (mins),
        .o_secs      (secs),
        .o_magnetron (magnetron),
        .o_lamp      (lamp),
        .o_beep      (beep),
        .o_presc_clr (presc_clr),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: time kept as total remaining seconds, evaluated once per clock edge.
    function automatic void model_step();
        bit clr_now;
        int mi, si;
        clr_now = 1'b0;
        if (reset) begin
            m_mode = M_IDLE; m_remain = 0; m_frac = 0; m_beep = 0; m_clr = 1'b0;
            exp_q.push_back('0);
            return;
        end
        if (cancel) begin
            m_mode = M_IDLE; m_remain = 0; m_frac = 0; m_beep = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (!door_open && !pause) begin
                    if (start) begin
                        if (m_remain > 0) begin
                            m_mode = M_RUN; m_frac = 0; clr_now = 1'b1;
                        end
                    end else if (load) begin
                        mi = int'(min_in); si = int'(sec_in);
                        if (mi > 99) mi = 99;
                        if (si > 59) si = 59;
                        m_remain = mi * 60 + si;
                    end
                end
                M_RUN: begin
                    if (door_open || pause) m_mode = M_PAUSED;
                    else if (tick && !m_clr) begin
                        m_frac++;
                        if (m_frac == TPS) begin
                            m_frac = 0;
                            m_remain--;
                            if (m_remain == 0) begin m_mode = M_DONE; m_beep = 0; end
                        end
                    end
                end
                M_PAUSED: if (!door_open && !pause && start) m_mode = M_RUN;
                default: if (tick) begin
                    m_beep++;
                    if (m_beep == BSECS * TPS) begin m_mode = M_IDLE; m_beep = 0; end
                end
            endcase
        end
        m_clr = clr_now;
        exp_q.push_back({7'(m_remain / 60), 6'(m_remain % 60), m_mode == M_RUN,
                         (m_mode == M_RUN) || door_open, m_mode == M_DONE, clr_now,
                         m_mode != M_IDLE});
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {mins, secs, magnetron, lamp, beep, presc_clr, busy};
            checks++;
            if (mon_got !== mon_exp) begin
                errors++;
                $display("FAIL outputs t=%0t got %0d:%0d mag/lamp/beep/clr/busy=%b required %0d:%0d flags=%b",
                         $time, mon_got[17:11], mon_got[10:5], mon_got[4:0],
                         mon_exp[17:11], mon_exp[10:5], mon_exp[4:0]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1; cyc();
            tick = 1'b0; cyc();
        end
    endtask

    task automatic do_load(input int m, input int s);
        min_in = 7'(m); sec_in = 6'(s);
        load = 1'b1; cyc();
        load = 1'b0; cyc();
    endtask

    task automatic do_start();
        start = 1'b1; cyc();
        start = 1'b0; cyc();
    endtask

    task automatic do_cancel();
        cancel = 1'b1; cyc();
        cancel = 1'b0; cyc();
    endtask

    int r;

    initial begin
        reset = 1'b1; idle(2);
        reset = 1'b0; idle(2);

        // 1: 01:02 counts down through 00:59
        do_load(1, 2); do_start(); ticks(12); do_cancel();
        // 2: 00:02 finishes, beeps 8 ticks, returns to IDLE
        do_load(0, 2); do_start(); ticks(8); ticks(8); idle(3);
        // 3: door opens mid-second at 00:05, resume keeps the partial second
        do_load(0, 6); do_start(); ticks(4); ticks(2);
        door_open = 1'b1; cyc(); ticks(10);
        door_open = 1'b0; cyc(); do_start(); ticks(2); idle(2); do_cancel();
        // 4: clamping and start on 00:00
        do_load(120, 63); do_load(0, 0); do_start(); idle(4);
        // 5: cancel coincident with the final tick
        do_load(0, 1); do_start(); ticks(3);
        tick = 1'b1; cancel = 1'b1; cyc();
        tick = 1'b0; cancel = 1'b0; idle(4);
        // 6: reset mid-run at 03:30
        do_load(3, 31); do_start(); ticks(4); ticks(2);
        reset = 1'b1; cyc(); reset = 1'b0; idle(3);

        repeat (4000) begin
            r = $urandom_range(0, 99);
            tick = ($urandom_range(0, 2) == 0) && !m_clr;
            if ($urandom_range(0, 63) == 0) door_open = ~door_open;
            load = 1'b0; start = 1'b0; pause = 1'b0; cancel = 1'b0; reset = 1'b0;
            if (r < 1) cancel = 1'b1;
            else if (r == 1) reset = ($urandom_range(0, 7) == 0);
            else if (r < 5) pause = 1'b1;
            else if (r < 15) start = 1'b1;
            else if (r < 19 && !door_open) begin
                load = 1'b1;
                min_in = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'd0;
                sec_in = 6'($urandom_range(0, 63));
            end
            cyc();
        end
        tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; cancel = 1'b0; reset = 1'b0;
        idle(3);
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
